// File: rtl/sub_64_bit_seq.sv
// Sequential 64-bit subtractor: diff = a + ~b + 1, one SLICE_W-bit slice per clock,
// least-significant slice first, with Y86 overflow/zero/sign flags and raw carry-out.
module sub_64_bit_seq #(
    parameter int SLICE_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic        busy,
    output logic        done,
    output logic [63:0] diff,
    output logic        overflow,
    output logic        zero,
    output logic        sign,
    output logic        carry_out
);

    localparam int N  = 64 / SLICE_W;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [63:0]     opa_q, opa_d;
    logic [63:0]     opb_n_q, opb_n_d;
    logic [63:0]     res_q, res_d;
    logic            carry_q, carry_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [63:0]     diff_q, diff_d;
    logic            ovf_q, ovf_d;
    logic            zero_q, zero_d;
    logic            sign_q, sign_d;
    logic            cout_q, cout_d;

    logic            accept_s;
    logic            last_s;
    int              idx_s;
    logic [SLICE_W:0] sum_s;

    // Start is honoured only outside RUN; busy operations never queue a request.
    assign accept_s = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign last_s   = (cnt_q == LAST);

    // State register and datapath flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            opa_q   <= 64'd0;
            opb_n_q <= 64'd0;
            res_q   <= 64'd0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= 64'd0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            sign_q  <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_n_q <= opb_n_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            sign_q  <= sign_d;
            cout_q  <= cout_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = accept_s ? ST_RUN : ST_IDLE;
            ST_RUN:  state_d = last_s ? ST_DONE : ST_RUN;
            ST_DONE: state_d = accept_s ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Slice adder, operand capture and completion-edge result/flag update.
    always_comb begin
        opa_d   = opa_q;
        opb_n_d = opb_n_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        sign_d  = sign_q;
        cout_d  = cout_q;
        idx_s   = int'(cnt_q) * SLICE_W;
        sum_s   = {1'b0, opa_q[idx_s +: SLICE_W]} + {1'b0, opb_n_q[idx_s +: SLICE_W]}
                + {{SLICE_W{1'b0}}, carry_q};
        if (accept_s) begin
            opa_d   = a;
            opb_n_d = ~b;
            carry_d = 1'b1;
            cnt_d   = '0;
        end else if (state_q == ST_RUN) begin
            res_d[idx_s +: SLICE_W] = sum_s[SLICE_W-1:0];
            carry_d = sum_s[SLICE_W];
            if (last_s) begin
                cnt_d  = '0;
                diff_d = res_d;
                cout_d = sum_s[SLICE_W];
                sign_d = res_d[63];
                zero_d = ~|res_d;
                // opb_n holds ~b, so equal top bits of opa/opb_n mean a[63] != b[63].
                ovf_d  = (opa_q[63] == opb_n_q[63]) && (res_d[63] != opa_q[63]);
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Output decode; all outputs come straight from flops.
    always_comb begin
        busy      = (state_q == ST_RUN);
        done      = (state_q == ST_DONE);
        diff      = diff_q;
        overflow  = ovf_q;
        zero      = zero_q;
        sign      = sign_q;
        carry_out = cout_q;
    end

endmodule

// File: tb/tb_sub_64_bit_seq.sv
// Scoreboard bench for sub_64_bit_seq: directed vectors on a SLICE_W=16 instance,
// then back-to-back runs on SLICE_W = 1, 8 and 64 instances.
module tb_sub_64_bit_seq;

    typedef struct {
        int          inst;
        int          cyc;
        logic [63:0] d;
        logic        ov;
        logic        z;
        logic        s;
        logic        c;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  start_v = 4'b0000;
    logic [63:0] a_s = 64'd0;
    logic [63:0] b_s = 64'd0;
    logic [3:0]  busy_v, done_v, ov_v, z_v, s_v, c_v;
    logic [63:0] diff_v [4];

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int W = (g == 0) ? 16 : (g == 1) ? 1 : (g == 2) ? 8 : 64;
        sub_64_bit_seq #(.SLICE_W(W)) u_dut (
            .clk(clk), .rst(rst), .start(start_v[g]), .a(a_s), .b(b_s),
            .busy(busy_v[g]), .done(done_v[g]), .diff(diff_v[g]),
            .overflow(ov_v[g]), .zero(z_v[g]), .sign(s_v[g]), .carry_out(c_v[g])
        );
    end

    function automatic int n_of(input int i);
        case (i)
            0: n_of = 4;
            1: n_of = 64;
            2: n_of = 8;
            default: n_of = 1;
        endcase
    endfunction

    function automatic exp_t hx(input logic [63:0] d, input logic ov, z, s, c);
        exp_t e;
        e.inst = 0; e.cyc = 0;
        e.d = d; e.ov = ov; e.z = z; e.s = s; e.c = c;
        return e;
    endfunction

    function automatic exp_t model(input logic [63:0] av, bv);
        logic [64:0] t;
        t = {1'b0, av} + {1'b0, ~bv} + 65'd1;
        return hx(t[63:0], (av[63] != bv[63]) && (t[63] != av[63]),
                  (t[63:0] == 64'd0), t[63], t[64]);
    endfunction

    task automatic chk(input string name, input logic [127:0] act, exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    // Drive one start for instance i; 'now' means the caller already sits on a negedge.
    task automatic drive_start(input int i, input logic [63:0] av, bv,
                               input bit push, input bit now, input exp_t e);
        exp_t q;
        if (!now) @(negedge clk);
        a_s = av; b_s = bv; start_v[i] = 1'b1;
        @(posedge clk);
        #1;
        start_v[i] = 1'b0;
        if (push) begin
            q = e; q.inst = i; q.cyc = cyc + n_of(i);
            sb.push_back(q);
        end
    endtask

    task automatic wait_done(input int i);
        bit seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            if (done_v[i]) seen = 1'b1;
        end
        if (!seen) begin
            n_chk++; n_err++;
            $display("FAIL wait_done: inst %0d got no done within 200 cycles", i);
        end
    endtask

    task automatic chk_all_zero(input string name, input int i);
        chk(name, {62'd0, busy_v[i], done_v[i], diff_v[i], ov_v[i], z_v[i], s_v[i], c_v[i]},
            128'd0);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: pops one expectation per done pulse and compares timing and results.
    initial forever begin
        exp_t e;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("busy_done_excl", {127'd0, busy_v[i] & done_v[i]}, 128'd0);
            if (done_v[i]) begin
                if (sb.size() == 0) begin
                    n_chk++; n_err++;
                    $display("FAIL unexpected_done: inst %0d at cycle %0d, none expected", i, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("done_timing", {64'(i), 64'(cyc)}, {64'(e.inst), 64'(e.cyc)});
                    chk("result", {60'd0, diff_v[i], ov_v[i], z_v[i], s_v[i], c_v[i]},
                        {60'd0, e.d, e.ov, e.z, e.s, e.c});
                end
            end
        end
    end

    initial begin
        exp_t e;
        logic [63:0] av, bv;
        start_v[0] = 1'b1;
        a_s = 64'd9; b_s = 64'd4;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) chk_all_zero("reset_state", i);
        start_v[0] = 1'b0;
        rst = 1'b0;

        // Directed vectors on SLICE_W=16.
        drive_start(0, 64'd5, 64'd2, 1'b1, 1'b0, hx(64'd3, 1'b0, 1'b0, 1'b0, 1'b1));
        chk("busy_after_start", {127'd0, busy_v[0]}, 128'd1);
        wait_done(0);
        drive_start(0, 64'd0, 64'd1, 1'b1, 1'b0,
                    hx(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0));
        wait_done(0);
        drive_start(0, 64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b0,
                    hx(64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1));
        wait_done(0);
        drive_start(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0,
                    hx(64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1, 1'b0));
        wait_done(0);

        // Equal operands, with a start pulse while busy that must be ignored.
        drive_start(0, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1, 1'b0,
                    hx(64'd0, 1'b0, 1'b1, 1'b0, 1'b1));
        @(negedge clk);
        a_s = 64'd1; b_s = 64'd2; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_done(0);
        repeat (3) @(negedge clk);
        chk("hold_after_ignored_start", {62'd0, busy_v[0], z_v[0], diff_v[0]}, {62'd0, 1'b0, 1'b1, 64'd0});

        // Reset mid-operation aborts with no done.
        drive_start(0, 64'd100, 64'd1, 1'b0, 1'b0, hx(64'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_all_zero("reset_mid_run", 0);
        @(negedge clk);
        rst = 1'b0;
        drive_start(0, 64'd10, 64'd3, 1'b1, 1'b0, hx(64'd7, 1'b0, 1'b0, 1'b0, 1'b1));
        wait_done(0);

        // Back-to-back sweep: each new start lands in the DONE cycle.
        for (int i = 1; i < 4; i++) begin
            drive_start(i, 64'd0, 64'd1, 1'b1, 1'b0, model(64'd0, 64'd1));
            for (int k = 0; k < 5; k++) begin
                wait_done(i);
                av = {$urandom, $urandom};
                bv = (k == 2) ? av : {$urandom, $urandom};
                if (k == 3) begin
                    av = 64'h8000_0000_0000_0000 | av;
                    bv = 64'h7FFF_FFFF_FFFF_FFFF & bv;
                end
                drive_start(i, av, bv, 1'b1, 1'b1, model(av, bv));
            end
            wait_done(i);
            repeat (2) @(negedge clk);
        end

        for (int k = 0; k < 50 && sb.size() != 0; k++) @(negedge clk);
        if (sb.size() != 0) begin
            n_chk++; n_err++;
            $display("FAIL drain: %0d expected results never arrived, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/sub_64_bit_seq.md
# sub_64_bit_seq

Sequential 64-bit two's-complement subtractor for the Y86 ALU. It computes `diff = a - b` as `a + ~b + 1`, one `SLICE_W`-bit slice per clock, least-significant slice first. It reports the Y86 condition flags (overflow, zero, sign) and the raw carry-out. It is the inverse operation of the 64-bit combinational adder and serves multi-cycle SUBQ/compare paths where one full-width ripple chain per cycle is too long.

## Interface
- `SLICE_W`, default 16: bits processed per cycle. Legal values are 1, 2, 4, 8, 16, 32 and 64. `N = 64/SLICE_W` is the slice count.
- `clk`  input  1  sole clock. All state changes on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `start`  input  1  request a new operation. Sampled only when not busy.
- `a`  input  64  signed minuend. Sampled together with `start`.
- `b`  input  64  signed subtrahend. Sampled together with `start`.
- `busy`  output  1  high while slices are being processed.
- `done`  output  1  one-cycle pulse. Results are valid from this cycle on.
- `diff`  output  64  signed result `a - b`, modulo 2^64.
- `overflow`  output  1  signed overflow.
- `zero`  output  1  `diff == 0`.
- `sign`  output  1  `diff[63]`.
- `carry_out`  output  1  carry out of bit 63 of `a + ~b + 1`. A value of 0 means an unsigned borrow occurred.

## Operation
- States:
  - IDLE: waiting for `start`.
  - RUN: processing slices.
  - DONE: `done` pulse cycle.
- On accepted `start`, latch the operands and initialise:
  - `opa = a`
  - `opb_n = ~b`
  - carry register = 1
  - slice counter = 0
  - state goes to RUN.
- RUN, each edge:
  - Slice `k` = bits `[k*SLICE_W +: SLICE_W]`.
  - `{c, s} = opa_slice + opb_n_slice + carry`.
  - `s` goes into the working result, `c` goes into the carry register, and the counter increments.
- After slice `N-1`:
  - Copy the working result to `diff`.
  - Write the flags:
    - `carry_out` = final carry.
    - `sign = diff[63]`.
    - `zero` = NOR of all 64 result bits.
    - `overflow = (a[63] != b[63]) && (diff[63] != a[63])`, using the latched operands.
  - State goes to DONE.
- DONE lasts one cycle:
  - With `start` high: accept the new operands and go to RUN (back-to-back).
  - Otherwise: go to IDLE.
- `start` is accepted in IDLE or DONE. While `busy=1` it is ignored: no queuing, and the operands are not re-sampled.
- `diff` and the flags are registered and are written only on the completion edge. They hold their values through IDLE and any later RUN until the next completion. Partial results are never visible.
- Arithmetic is pure modulo-2^64. No saturation. The counter width is `clog2(N)`, or 1 bit when `N=1`.

## Timing
- Reset, asynchronous: state IDLE, `busy=0`, `done=0`, `diff=0`, `overflow=0`, `zero=0`, `sign=0`, `carry_out=0`, counter 0.
- Reset mid-RUN aborts the operation. No `done` follows and outputs go to their reset values.
- Let E0 be the edge that samples `start`. Then:
  - `busy=1` from E0 through edge E(N).
  - Slices are computed at edges E1..EN.
  - `diff` and the flags update at edge EN.
  - `done=1` for the cycle following EN.
  - Latency is N cycles from start-sampling to `done`.
- With `SLICE_W=16`: `done` comes 4 cycles after the `start` edge.
- With `SLICE_W=64`: `done` comes 1 cycle after the `start` edge.
- Throughput is one operation per N+1 cycles. With back-to-back starts, a start accepted in DONE gives N+1 cycles per operation and `done` spaced N+1 apart.
- `busy` and `done` are never high together.
- `start` asserted in the same cycle as `rst` is ignored.

## Test plan
- Basic: `a=5`, `b=2`, `SLICE_W=16` → `done` 4 cycles after start, `diff=3`, `carry_out=1`, `overflow=0`, `zero=0`, `sign=0`.
- Borrow across slices: `a=0`, `b=1` → `diff=0xFFFF_FFFF_FFFF_FFFF`, `sign=1`, `carry_out=0`, `overflow=0`. Checks carry propagation through all slices.
- Overflow:
  - `a=0x8000_0000_0000_0000`, `b=1` → `diff=0x7FFF_FFFF_FFFF_FFFF`, `overflow=1`, `sign=0`.
  - `a=0x7FFF_FFFF_FFFF_FFFF`, `b=-1` → `diff=0x8000_0000_0000_0000`, `overflow=1`.
- Zero and ignored start: `a=b=0x1234_5678_9ABC_DEF0` → `zero=1`, `carry_out=1`. Pulse `start` with new operands while busy → ignored. Exactly one `done` and the result is unchanged.
- Reset mid-operation: assert `rst` two cycles after start → all outputs 0 immediately, no `done`. The next operation (`a=10`, `b=3`) returns `diff=7`.
- Parameter sweep: `SLICE_W` ∈ {1, 8, 64} with random operands and back-to-back starts in the DONE cycle → `done` every N+1 cycles, results match `a-b` modulo 2^64 and the flag equations.
